// File: rtl/fsk_mod.sv
// fsk_mod: phase-continuous binary FSK modulator fed by a serial bit source.
//
// A 32-bit phase accumulator advances by FCW0 or FCW1 depending on the bit
// being sent. Its top 8 bits address a sine lookup, and the result is
// registered as an offset-binary DAC sample. The accumulator is never cleared
// at a symbol boundary, so the waveform stays phase-continuous when the
// frequency switches. Once per symbol a one-cycle bit_req pulse asks the
// upstream source for its next bit.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   enable     in   run request; low pauses modulation (phase and sample hold)
//   code       in   serial data bit from the source (changes on negedge)
//   bit_req    out  one-cycle pulse in the last cycle of each symbol
//   cur_bit    out  bit currently being modulated
//   sym_strobe out  one-cycle pulse in the cycle after a new bit is latched
//   fsk_out    out  8-bit offset-binary sine sample (1..255)
//
// Optional build macro FSK_DIFF_EN: when defined, the output bit is
// differentially encoded (cur_bit <= code ^ cur_bit at each boundary).

module fsk_mod #(
   parameter int unsigned SYM_LEN = 16,
   parameter logic [31:0] FCW0    = 32'h0200_0000,
   parameter logic [31:0] FCW1    = 32'h0400_0000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       code,
   output logic       bit_req,
   output logic       cur_bit,
   output logic       sym_strobe,
   output logic [7:0] fsk_out
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [15:0] LAST = 16'(SYM_LEN - 1);

   state_t      state_q, state_d;
   logic [15:0] sym_cnt_q, sym_cnt_d, cnt_inc;
   logic [31:0] phase_q, phase_d;
   logic        cur_bit_q, cur_bit_d;
   logic        bit_req_q, bit_req_d;
   logic        strobe_q, strobe_d;
   logic [7:0]  fsk_q, fsk_d;
   logic [7:0]  sine;
   logic [7:0]  addr;
   logic [6:0]  qidx;
   logic [6:0]  mag;
   logic        latch_bit;

   // First quadrant of round(127*sin(2*pi*k/256)), k = 0..64.
   function automatic logic [6:0] qrom(input logic [6:0] k);
      logic [6:0] v;
      case (k)
         7'd0:  v = 7'd0;   7'd1:  v = 7'd3;   7'd2:  v = 7'd6;   7'd3:  v = 7'd9;
         7'd4:  v = 7'd12;  7'd5:  v = 7'd16;  7'd6:  v = 7'd19;  7'd7:  v = 7'd22;
         7'd8:  v = 7'd25;  7'd9:  v = 7'd28;  7'd10: v = 7'd31;  7'd11: v = 7'd34;
         7'd12: v = 7'd37;  7'd13: v = 7'd40;  7'd14: v = 7'd43;  7'd15: v = 7'd46;
         7'd16: v = 7'd49;  7'd17: v = 7'd51;  7'd18: v = 7'd54;  7'd19: v = 7'd57;
         7'd20: v = 7'd60;  7'd21: v = 7'd63;  7'd22: v = 7'd65;  7'd23: v = 7'd68;
         7'd24: v = 7'd71;  7'd25: v = 7'd73;  7'd26: v = 7'd76;  7'd27: v = 7'd78;
         7'd28: v = 7'd81;  7'd29: v = 7'd83;  7'd30: v = 7'd85;  7'd31: v = 7'd88;
         7'd32: v = 7'd90;  7'd33: v = 7'd92;  7'd34: v = 7'd94;  7'd35: v = 7'd96;
         7'd36: v = 7'd98;  7'd37: v = 7'd100; 7'd38: v = 7'd102; 7'd39: v = 7'd104;
         7'd40: v = 7'd106; 7'd41: v = 7'd107; 7'd42: v = 7'd109; 7'd43: v = 7'd111;
         7'd44: v = 7'd112; 7'd45: v = 7'd113; 7'd46: v = 7'd115; 7'd47: v = 7'd116;
         7'd48: v = 7'd117; 7'd49: v = 7'd118; 7'd50: v = 7'd120; 7'd51: v = 7'd121;
         7'd52: v = 7'd122; 7'd53: v = 7'd122; 7'd54: v = 7'd123; 7'd55: v = 7'd124;
         7'd56: v = 7'd125; 7'd57: v = 7'd125; 7'd58: v = 7'd126; 7'd59: v = 7'd126;
         7'd60: v = 7'd126; 7'd61: v = 7'd127; 7'd62: v = 7'd127; 7'd63: v = 7'd127;
         7'd64: v = 7'd127;
         default: v = '0;
      endcase
      return v;
   endfunction

   // Quadrant mirroring: the 2nd/4th quadrants read the table backwards
   // (index 64-k), and the 3rd/4th quadrants subtract from mid-scale.
   always_comb begin
      addr = phase_q[31:24];
      qidx = addr[6] ? (7'd64 - {1'b0, addr[5:0]}) : {1'b0, addr[5:0]};
      mag  = qrom(qidx);
      sine = addr[7] ? (8'd128 - {1'b0, mag}) : (8'd128 + {1'b0, mag});
   end

   always_comb begin
      cnt_inc = (sym_cnt_q == LAST) ? '0 : sym_cnt_q + 16'd1;
`ifdef FSK_DIFF_EN
      latch_bit = code ^ cur_bit_q;
`else
      latch_bit = code;
`endif
      state_d   = state_q;
      sym_cnt_d = sym_cnt_q;
      phase_d   = phase_q;
      cur_bit_d = cur_bit_q;
      fsk_d     = fsk_q;
      bit_req_d = 1'b0;
      strobe_d  = 1'b0;
      case (state_q)
         IDLE: begin
            sym_cnt_d = '0;
            // The wake-up edge is itself a symbol boundary.
            if (enable) begin
               state_d   = RUN;
               cur_bit_d = latch_bit;
               strobe_d  = 1'b1;
               sym_cnt_d = cnt_inc;
               bit_req_d = (cnt_inc == LAST);
            end
         end
         RUN: begin
            if (enable) begin
               if (sym_cnt_q == '0) begin
                  cur_bit_d = latch_bit;
                  strobe_d  = 1'b1;
               end
               sym_cnt_d = cnt_inc;
               bit_req_d = (cnt_inc == LAST);
               // Boundary cycle still uses the old bit's frequency.
               phase_d   = phase_q + (cur_bit_q ? FCW1 : FCW0);
               fsk_d     = sine;
            end else begin
               state_d   = IDLE;
               sym_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sym_cnt_q <= '0;
         phase_q   <= '0;
         cur_bit_q <= 1'b0;
         bit_req_q <= 1'b0;
         strobe_q  <= 1'b0;
         fsk_q     <= 8'd128;
      end else begin
         state_q   <= state_d;
         sym_cnt_q <= sym_cnt_d;
         phase_q   <= phase_d;
         cur_bit_q <= cur_bit_d;
         bit_req_q <= bit_req_d;
         strobe_q  <= strobe_d;
         fsk_q     <= fsk_d;
      end
   end

   assign bit_req    = bit_req_q;
   assign cur_bit    = cur_bit_q;
   assign sym_strobe = strobe_q;
   assign fsk_out    = fsk_q;

endmodule

// File: tb/tb_fsk_mod.sv
// Bench for fsk_mod: a reference-model scoreboard on every cycle for two
// instances (default parameters, and SYM_LEN=2 with a slow 1-step-per-clock
// FCW), plus directed timing, sine check-point, pause/resume, reset and
// encoding sequences.

module tb_fsk_mod;

   localparam real PI = 3.14159265358979;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       code;
   logic       code2 = 1'b0;
   logic [7:0] src = 8'hAA;
   logic       bit_req, cur_bit, sym_strobe;
   logic [7:0] fsk_out;
   logic       bit_req2, cur_bit2, sym_strobe2;
   logic [7:0] fsk_out2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign code = src[7];

   fsk_mod dut (
      .clk(clk), .rst(rst), .enable(enable), .code(code),
      .bit_req(bit_req), .cur_bit(cur_bit), .sym_strobe(sym_strobe),
      .fsk_out(fsk_out)
   );

   fsk_mod #(.SYM_LEN(2), .FCW0(32'h0100_0000), .FCW1(32'h0100_0000)) dut2 (
      .clk(clk), .rst(rst), .enable(enable), .code(code2),
      .bit_req(bit_req2), .cur_bit(cur_bit2), .sym_strobe(sym_strobe2),
      .fsk_out(fsk_out2)
   );

   // Bit source: rotates one position on the negedge of each bit request.
   always @(negedge clk) if (bit_req === 1'b1) src = {src[6:0], src[7]};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int tb_sine(input int a);
      real x;
      x = 127.0 * $sin(2.0 * PI * a / 256.0);
      if (x >= 0.0) return 128 + $rtoi(x + 0.5);
      else          return 128 - $rtoi(0.5 - x);
   endfunction

   typedef struct {
      bit          run;
      int unsigned cnt;
      logic [31:0] ph;
      logic        cur;
      logic [7:0]  fsk;
      logic        breq;
      logic        strb;
   } mdl_t;

   typedef struct {
      logic       breq;
      logic       cur;
      logic       strb;
      logic [7:0] fsk;
   } exp_t;

   function automatic mdl_t mstep(input mdl_t s, input logic r, input logic en, input logic c,
                                  input int unsigned sym, input logic [31:0] f0, input logic [31:0] f1);
      mdl_t n;
      n = s;
      if (r) begin
         n.run = 0; n.cnt = 0; n.ph = '0; n.cur = 1'b0; n.fsk = 8'd128;
         n.breq = 1'b0; n.strb = 1'b0;
      end else if (!en) begin
         n.run = 0; n.cnt = 0; n.breq = 1'b0; n.strb = 1'b0;
      end else begin
         n.strb = (s.cnt == 0);
         if (s.run) begin
            n.fsk = 8'(tb_sine(int'(s.ph[31:24])));
            n.ph  = s.ph + (s.cur ? f1 : f0);
         end
         if (s.cnt == 0) begin
`ifdef FSK_DIFF_EN
            n.cur = c ^ s.cur;
`else
            n.cur = c;
`endif
         end
         n.cnt  = (s.cnt == sym - 1) ? 0 : s.cnt + 1;
         n.breq = (n.cnt == sym - 1);
         n.run  = 1;
      end
      return n;
   endfunction

   mdl_t m1, m2;
   exp_t q1[$], q2[$];

   always @(posedge clk) begin
      exp_t e;
      m1 = mstep(m1, rst, enable, code, 16, 32'h0200_0000, 32'h0400_0000);
      m2 = mstep(m2, rst, enable, code2, 2, 32'h0100_0000, 32'h0100_0000);
      e.breq = m1.breq; e.cur = m1.cur; e.strb = m1.strb; e.fsk = m1.fsk;
      q1.push_back(e);
      e.breq = m2.breq; e.cur = m2.cur; e.strb = m2.strb; e.fsk = m2.fsk;
      q2.push_back(e);
      #1;
      e = q1.pop_front();
      chk("sb_breq", bit_req, e.breq);
      chk("sb_cur", cur_bit, e.cur);
      chk("sb_strobe", sym_strobe, e.strb);
      chk("sb_fsk", fsk_out, e.fsk);
      e = q2.pop_front();
      chk("sb2_breq", bit_req2, e.breq);
      chk("sb2_cur", cur_bit2, e.cur);
      chk("sb2_strobe", sym_strobe2, e.strb);
      chk("sb2_fsk", fsk_out2, e.fsk);
   end

   typedef struct {
      int         a;
      logic [7:0] fsk;
   } vec_t;

   function automatic logic exp_cur(input int k);
`ifdef FSK_DIFF_EN
      return ((k / 2) % 2) == 0;
`else
      return (k % 2) == 0;
`endif
   endfunction

   initial begin
      vec_t tab[11];
      logic [7:0] dexp[4];
      logic [7:0] snap;
      int ti;
      int prev;
      int d;

      tab[0]  = '{0, 8'd128};  tab[1]  = '{16, 8'd177}; tab[2]  = '{32, 8'd218};
      tab[3]  = '{48, 8'd245}; tab[4]  = '{64, 8'd255}; tab[5]  = '{96, 8'd218};
      tab[6]  = '{128, 8'd128}; tab[7] = '{160, 8'd38}; tab[8]  = '{192, 8'd1};
      tab[9]  = '{224, 8'd38}; tab[10] = '{256, 8'd128};
`ifdef FSK_DIFF_EN
      dexp = '{8'd1, 8'd0, 8'd0, 8'd1};
`else
      dexp = '{8'd1, 8'd1, 8'd0, 8'd1};
`endif

      // Reset held with enable high.
      rst = 1'b1; enable = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_fsk", fsk_out, 8'd128);
         chk("rst_breq", bit_req, 1'b0);
         chk("rst_strobe", sym_strobe, 1'b0);
         chk("rst_cur", cur_bit, 1'b0);
      end

      // Continuous run: symbol timing, bit sequence, continuity, sine points.
      rst = 1'b0;
      ti = 0;
      prev = 128;
      for (int n = 0; n < 260; n++) begin
         @(negedge clk);
         chk("strobe_timing", sym_strobe, (n % 16) == 0);
         chk("breq_timing", bit_req, (n % 16) == 14);
         chk("breq_len2", bit_req2, (n % 2) == 0);
         if ((n % 16) == 0) chk("cur_seq", cur_bit, exp_cur(n / 16));
         d = int'(fsk_out) - prev;
         if (d < 0) d = -d;
         checks++;
         if (d > 13) begin
            errors++;
            $display("FAIL continuity: step %0d required <= 13 at %0t", d, $time);
         end
         prev = int'(fsk_out);
         if (ti < 11 && tab[ti].a + 1 == n) begin
            chk("sine_point", fsk_out2, tab[ti].fsk);
            ti++;
         end
      end

      // Pause mid-symbol for 5 cycles, then resume.
      enable = 1'b0;
      snap = m1.fsk;
      repeat (5) begin
         @(negedge clk);
         chk("pause_fsk", fsk_out, snap);
         chk("pause_strobe", sym_strobe, 1'b0);
         chk("pause_breq", bit_req, 1'b0);
      end
      enable = 1'b1;
      for (int j = 0; j <= 16; j++) begin
         @(negedge clk);
         chk("resume_strobe", sym_strobe, (j == 0) || (j == 16));
         chk("resume_breq", bit_req, j == 14);
      end

      // Reset mid-symbol.
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_fsk", fsk_out, 8'd128);
      chk("rstmid_cur", cur_bit, 1'b0);
      chk("rstmid_strobe", sym_strobe, 1'b0);
      chk("rstmid_breq", bit_req, 1'b0);
      chk("rstmid_fsk2", fsk_out2, 8'd128);

      // Code stream 1,1,0,1 from reset.
      src = 8'hD0;
      rst = 1'b0;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if ((n % 16) == 0) chk("enc_seq", cur_bit, dexp[n / 16][0]);
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
